mipi_arb: RTL

MIPI_ARB -- requirements
Module: mipi_arb

---
 rtl/mipi_arb_pkg.sv | 20 ++
 rtl/mipi_arb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mipi_arb_pkg.sv
// Shared definitions for the two-requester mipi arbiter: state encoding,
// requester count, byte width and the shared counter sizing rule.
package mipi_arb_pkg;

    localparam int N_REQ  = 2;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRAIN,
        ST_GAP
    } state_t;

    // One counter times both the inter-frame gap and the watchdog.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/mipi_arb.sv
// Round-robin arbiter giving one of two frame sources exclusive use of the mipi
// block, with a watchdog that drains a stalled frame and an enforced inter-frame gap.
module mipi_arb
    import mipi_arb_pkg::*;
#(
    parameter int GAP_CYC  = 16,
    parameter int IDLE_MAX = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame0,
    input  logic              frame1,
    input  logic [BYTE_W-1:0] din0,
    input  logic [BYTE_W-1:0] din1,
    input  logic              din_rdy0,
    input  logic              din_rdy1,
    output logic              din_ack0,
    output logic              din_ack1,
    output logic              b_req,
    output logic [BYTE_W-1:0] d_in,
    output logic              d_req,
    input  logic              d_ack,
    output logic [N_REQ-1:0]  grant,
    output logic              abort
);

    localparam int              CNT_W    = cnt_width(GAP_CYC, IDLE_MAX);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(IDLE_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_own;
    logic             r_last;
    logic             r_abort;
    logic [CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0]  w_frame;
    logic [N_REQ-1:0]  w_rdy;
    logic [BYTE_W-1:0] w_din [N_REQ];
    logic [N_REQ-1:0]  w_ack;
    logic              w_own_frame;
    logic              w_own_rdy;
    logic              w_wd_expire;
    logic              w_pick;

    assign w_frame     = {frame1, frame0};
    assign w_rdy       = {din_rdy1, din_rdy0};
    assign w_din[0]    = din0;
    assign w_din[1]    = din1;
    assign w_own_frame = w_frame[r_own];
    assign w_own_rdy   = w_rdy[r_own];
    // Tie goes to the requester that did not own the previous frame.
    assign w_pick      = (&w_frame) ? ~r_last : w_frame[1];
    assign w_wd_expire = (r_state == ST_GRANT) && !w_own_rdy && (r_cnt == WD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (|w_frame)          w_next_state = ST_GRANT;
            ST_GRANT: if (!w_own_frame)      w_next_state = ST_GAP;
                      else if (w_wd_expire)  w_next_state = ST_DRAIN;
            ST_DRAIN: if (!w_own_frame)      w_next_state = ST_GAP;
            ST_GAP:   if (r_cnt == '0)       w_next_state = ST_IDLE;
            default:                         w_next_state = ST_IDLE;
        endcase
    end

    // Owner, round-robin pointer, abort pulse and the shared gap/watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_own   <= 1'b0;
            r_last  <= 1'b1;
            r_abort <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_abort <= w_wd_expire && w_own_frame;
            case (r_state)
                ST_IDLE: if (|w_frame) begin
                    r_own <= w_pick;
                    r_cnt <= '0;
                end
                ST_GRANT: begin
                    if (!w_own_frame) begin
                        r_last <= r_own;
                        r_cnt  <= GAP_LOAD;
                    end else if (w_own_rdy) begin
                        r_cnt <= '0;
                    end else if (r_cnt != WD_LAST) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: if (!w_own_frame) begin
                    r_last <= r_own;
                    r_cnt  <= GAP_LOAD;
                end
                ST_GAP: if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        b_req = 1'b0;
        d_req = 1'b0;
        d_in  = '0;
        grant = '0;
        w_ack = '0;
        case (r_state)
            ST_GRANT: begin
                b_req        = 1'b1;
                d_req        = w_own_rdy;
                d_in         = w_din[r_own];
                grant[r_own] = 1'b1;
                w_ack[r_own] = d_ack & w_own_rdy;
            end
            ST_DRAIN: w_ack[r_own] = w_own_rdy;
            default: ;
        endcase
    end

    assign din_ack0 = w_ack[0];
    assign din_ack1 = w_ack[1];
    assign abort    = r_abort;

endmodule
